// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and sizing helpers for the divided-strobe scheduler.
package div_sched_pkg;
  typedef enum logic [1:0] {OFF, RUN, PEND} ch_state_t;
  localparam int W_DEF = 9;
  localparam int N_CH_DEF = 4;
  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int CH_W = (N_CH_DEF > 1) ? $clog2(N_CH_DEF) : 1;
endpackage

// File: rtl/div_sched_if.sv
// div_sched_if: valid/ready configuration port selecting a channel, ratio and enable.
interface div_sched_if #(parameter int N_CH = 4, parameter int W = 9);
  import div_sched_pkg::*;
  localparam int CW = ch_w(N_CH);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;
  logic          cfg_en;
  modport master(output cfg_valid, cfg_ch, cfg_div, cfg_en, input cfg_ready);
  modport slave(input cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready);
endinterface

// File: rtl/div_sched_ch.sv
// div_sched_ch: one channel's OFF/RUN/PEND FSM, counter, deferred ratio and output flops.
module div_sched_ch import div_sched_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         RE_n,
  input  logic         i_wr,
  input  logic         i_en,
  input  logic [W-1:0] i_div,
  input  logic         i_sync,
  output logic         o_tick,
  output logic         o_clk_div,
  output logic         o_pend
);
  ch_state_t    r_state, w_next;
  logic [W-1:0] r_cnt, r_div, r_pend_div;
  logic         r_pend_en, r_tick, r_clk;
  logic         w_act, w_tc, w_apply, w_start;

  always_ff @(posedge clk or negedge RE_n)
    if (!RE_n) r_state <= OFF;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      OFF:     w_next = w_start ? RUN : OFF;
      RUN:     w_next = i_wr ? PEND : RUN;
      PEND:    w_next = w_apply ? (r_pend_en ? RUN : OFF) : PEND;
      default: w_next = OFF;
    endcase
  end

  always_comb begin
    w_act   = r_state != OFF;
    w_tc    = w_act && (r_cnt == r_div - 1'b1);
    w_apply = (r_state == PEND) && (i_sync || w_tc);
    w_start = (r_state == OFF) && i_wr && i_en;
    o_pend  = r_state == PEND;
  end

  // sync outranks terminal count: it realigns the phase and suppresses that edge's tick
  always_ff @(posedge clk or negedge RE_n)
    if (!RE_n) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_pend_div <= '0;
      r_pend_en  <= 1'b0;
      r_tick     <= 1'b0;
      r_clk      <= 1'b0;
    end else begin
      r_tick <= w_tc && !i_sync;
      r_cnt  <= (w_start || (w_act && (i_sync || w_tc))) ? '0 : w_act ? r_cnt + 1'b1 : r_cnt;
      r_clk  <= (w_start || (w_act && i_sync)) ? 1'b0 : w_tc ? ~r_clk : r_clk;
      r_div  <= w_start ? i_div : (w_apply && r_pend_en) ? r_pend_div : r_div;
      if (r_state == RUN && i_wr) begin
        r_pend_div <= i_div;
        r_pend_en  <= i_en;
      end
    end

  assign o_tick    = r_tick;
  assign o_clk_div = r_clk;
endmodule

// File: rtl/div_sched.sv
// div_sched: multi-channel clock-enable scheduler; decodes config writes and fans out sync.
module div_sched import div_sched_pkg::*; #(
  parameter int N_CH = 4,
  parameter int W    = W_DEF
) (
  input  logic            clk,
  input  logic            RE_n,
  div_sched_if.slave      cfg,
  input  logic            sync,
  output logic [N_CH-1:0] tick_out,
  output logic [N_CH-1:0] clk_div_out,
  output logic [N_CH-1:0] pend
);
  localparam int CW = ch_w(N_CH);
  logic w_hit, w_acc, w_en;

  // out-of-range channel numbers are always ready and simply dropped
  assign w_hit         = int'(cfg.cfg_ch) < N_CH;
  assign cfg.cfg_ready = w_hit ? ~pend[cfg.cfg_ch] : 1'b1;
  assign w_acc         = cfg.cfg_valid && cfg.cfg_ready && w_hit;
  assign w_en          = cfg.cfg_en && (|cfg.cfg_div);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    div_sched_ch #(.W(W)) u_ch (
      .clk      (clk),
      .RE_n     (RE_n),
      .i_wr     (w_acc && (cfg.cfg_ch == CW'(i))),
      .i_en     (w_en),
      .i_div    (cfg.cfg_div),
      .i_sync   (sync),
      .o_tick   (tick_out[i]),
      .o_clk_div(clk_div_out[i]),
      .o_pend   (pend[i])
    );
  end
endmodule

// File: doc/div_sched.md
# div_sched

Multi-channel clock-enable scheduler. Generates `N_CH` independent divided strobes and square-wave clocks from `clk`, each with a divide ratio configured at run time over a valid/ready port. Ratio changes are deferred to each channel's terminal count, so no output glitches or short periods occur. Sits between the control/register logic and any block that needs a slow enable or divided clock, replacing fixed-ratio dividers.

## Interface
Parameters:
- `N_CH`, 4, number of channels (1..16)
- `W`, 9, divide-ratio and counter width

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `RE_n` in 1: reset, asynchronous assert, active-low.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: `~pend[cfg_ch]`; combinational from `cfg_ch`.
- `cfg_ch` in `$clog2(N_CH)` (min 1): target channel.
- `cfg_div` in W: divide ratio D.
- `cfg_en` in 1: 1 = run, 0 = stop.
- `sync` in 1: single-cycle phase-realign pulse for all running channels.
- `tick_out` out N_CH: one-cycle strobe every D cycles, registered.
- `clk_div_out` out N_CH: toggles on every tick (period 2D, 50% duty), registered.
- `pend` out N_CH: channel has an update queued.

## Operation
- The handshake completes at a posedge where `cfg_valid & cfg_ready`. A `cfg_ch` value ≥ N_CH is accepted and ignored.
- `cfg_en=1` with `cfg_div=0` is treated as `cfg_en=0`.
- Per-channel FSM has three states: OFF, RUN, PEND.
  - **OFF.** On an accepted write with enable: `div←cfg_div`, `cnt←0`, `clk_div←0`, go to RUN. On a write with disable: stay OFF, no change.
  - **RUN.** `cnt` counts 0..div−1. When `cnt==div−1`: `cnt←0`, `tick←1`, `clk_div` toggles. On an accepted write: store `pend_div`/`pend_en`, go to PEND.
  - **PEND.** Counts as in RUN with the old div. At terminal count, the tick and toggle fire with the old ratio. Then:
    - `pend_en=1`: `div←pend_div`, `cnt←0`, go to RUN.
    - `pend_en=0`: go to OFF, `clk_div` holds its level.
- `sync` is applied at the posedge where it is sampled high. It has priority over terminal count.
  - RUN/PEND channels: `cnt←0`, `clk_div←0`, no tick on that edge.
  - PEND channels: the pending update is applied at the same edge and the channel leaves PEND.
  - OFF channels: unaffected.
- Write at the same edge as terminal count (RUN state): the tick fires with the old div, and the channel enters PEND. The new value waits for the next terminal count.
- Arithmetic is unsigned W-bit. `cnt` never exceeds div−1. D=1 gives `tick_out` constantly high and `clk_div_out` toggling every cycle.

## Timing
- Reset values:
  - `tick_out`, `clk_div_out`, `pend` = 0.
  - All channels OFF, `cnt=0`, `div=0`.
  - `cfg_ready=1`.
- Reset mid-operation clears everything immediately, including pending updates.
- Enable write accepted at edge k: first `tick_out` is high in the cycle after edge k+D, then every D cycles. `clk_div_out` toggles at edges k+D, k+2D, and so on.
- Deferred update: the first tick with the new ratio D' comes D' cycles after the old-ratio terminal tick.
- `pend[i]` rises the edge after acceptance and falls at the apply edge. `cfg_ready` for that channel follows the same timing.
- After `sync` at edge s: first tick is at edge s+D.

## Structure
- `div_sched_pkg` holds:
  - `ch_state_t` enum {OFF, RUN, PEND};
  - the default `W`;
  - `localparam CH_W = (N_CH>1) ? $clog2(N_CH) : 1`.
- Sub-module `div_sched_ch` holds one channel's FSM, counter, pending registers and output flops. It is instantiated N_CH times via generate.
- The top level holds the config decode, `cfg_ready` mux and `sync` fan-out only.

## Test plan
1. Reset, then write ch0 D=3 enable at edge 0 → `tick_out[0]` at edges 3, 6, 9; `clk_div_out[0]` period 6; other channels stay 0.
2. ch1 running D=4, write D=2 mid-count → `pend[1]=1` and `cfg_ready=0` with `cfg_ch=1`. Tick at the old terminal count. Next ticks 2 cycles apart; `pend` clears at the apply edge.
3. Second write to a pending channel while `cfg_valid` is held → not accepted until `pend` clears, then accepted. Writes to other channels are accepted meanwhile.
4. Channels with D=1, 5, 7 running; pulse `sync` → all `cnt` reset, `clk_div_out=0`. Next ticks at s+1, s+5, s+7. A pending update on any of them is applied at s.
5. Write `cfg_en=0` to running ch2 D=5 → one final tick at terminal count, then no ticks and `clk_div_out[2]` holds. Write with `cfg_div=0`, `cfg_en=1` → channel stays OFF.
6. Assert `RE_n=0` mid-run, asynchronous to `clk`, with a pending update → all outputs 0 immediately. After release, no ticks until a new enable write.
